// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM request arbiter.
// Imported by the interface, the winner-select sub-module and the top.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_WAIT_RD = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;

  // Index width for a port count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and controller-side bus of the SDRAM arbiter.
// slave = arbiter view, master = requesters/controller (testbench) view.
interface sdram_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_rw;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_rw;
  logic [DATA_W-1:0]           mem_data_in;
  logic                        mem_in_valid;
  logic                        mem_busy;
  logic [DATA_W-1:0]           mem_data_out;
  logic                        mem_out_valid;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  mem_busy, mem_data_out, mem_out_valid,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_rw, mem_data_in, mem_in_valid
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    output mem_busy, mem_data_out, mem_out_valid,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_rw, mem_data_in, mem_in_valid
  );
endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner select: round-robin after i_last, or lowest index
// wins when SDRAM_ARB_FIXED_PRIO_EN is defined.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic                 o_any,
  output logic [IDX_W-1:0]     o_win
);

  assign o_any = |i_req;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    o_win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i_req[IDX_W'(i)]) o_win = IDX_W'(i);
    end
  end
`else
  // Walk offsets from farthest to nearest so the port closest after
  // i_last is the final (winning) assignment.
  always_comb begin
    int idx;
    idx   = 0;
    o_win = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = int'(i_last) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (i_req[IDX_W'(idx)]) o_win = IDX_W'(idx);
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port arbiter in front of an SDRAM controller: one command and one
// read in flight. Define SDRAM_ARB_FIXED_PRIO_EN for fixed-priority grants.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic [IDX_W-1:0]     r_last_grant;
  logic [IDX_W-1:0]     r_owner;
  logic                 r_rw;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [NUM_PORTS-1:0] r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic                 w_any;
  logic                 w_grant;
  logic [IDX_W-1:0]     w_win;

  sdram_arb_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last_grant),
    .o_any  (w_any),
    .o_win  (w_win)
  );

  // Grant is gated by rst so req_ready stays low while held in reset.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !bus.mem_busy && rst) begin
          w_grant      = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE:   w_next_state = ST_HOLD;
      ST_HOLD:    w_next_state = r_rw ? ST_IDLE : ST_WAIT_RD;
      ST_WAIT_RD: if (bus.mem_out_valid) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_grant) bus.req_ready = NUM_PORTS'(1) << w_win;
  end

  assign bus.mem_in_valid = (r_state == ST_ISSUE);
  assign bus.mem_addr     = r_addr;
  assign bus.mem_rw       = r_rw;
  assign bus.mem_data_in  = r_wdata;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
      r_owner      <= '0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= '0;
      if (w_grant) begin
        r_owner <= w_win;
        r_rw    <= bus.req_rw[w_win];
        r_addr  <= bus.req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        r_wdata <= bus.req_wdata[int'(w_win)*DATA_W +: DATA_W];
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        r_last_grant <= w_win;
`endif
      end
      if (r_state == ST_WAIT_RD && bus.mem_out_valid) begin
        r_rsp_rdata <= bus.mem_data_out;
        r_rsp_valid <= NUM_PORTS'(1) << r_owner;
      end
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning the number of requester ports (legal values 2..4).
REQ-002 SHALL have parameter ADDR_W, default 23, meaning the word address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_PORTS  per-port request pending.
REQ-007 req_ready  out  NUM_PORTS  per-port one-cycle accept strobe.
REQ-008 req_rw  in  NUM_PORTS  per-port 1=write, 0=read.
REQ-009 req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  NUM_PORTS*DATA_W  per-port write data, packed the same way.
REQ-011 rsp_valid  out  NUM_PORTS  one-cycle read-data strobe to the owning port.
REQ-012 rsp_rdata  out  DATA_W  read data shared by all ports; meaningful only while a rsp_valid bit is high.
REQ-013 mem_addr/mem_rw/mem_data_in  out  ADDR_W/1/DATA_W  command to the SDRAM controller.
REQ-014 mem_in_valid  out  1  command strobe.
REQ-015 mem_busy  in  1  controller queue full.
REQ-016 mem_data_out  in  DATA_W  controller read data.
REQ-017 mem_out_valid  in  1  controller read-data strobe.

Function
REQ-018 States: IDLE, ISSUE, HOLD, WAIT_RD; at most one command and one read outstanding.
REQ-019 IDLE: a grant occurs when any req_valid is high and mem_busy=0. In that same cycle the block SHALL assert req_ready[w] combinationally for the winner w, capture its rw/addr/wdata and owner index, and go to ISSUE.
REQ-020 IDLE with mem_busy=1 or no req_valid: no req_ready, stay in IDLE.
REQ-021 ISSUE: mem_in_valid=1 for exactly one cycle, with the captured command on the mem_* outputs; then go to HOLD.
REQ-022 HOLD: one cycle with mem_in_valid=0 and mem_busy ignored, which covers the controller's registered busy. Then go to WAIT_RD if the command was a read, otherwise to IDLE.
REQ-023 WAIT_RD: on mem_out_valid=1, register mem_data_out into rsp_rdata and pulse rsp_valid[owner] the next cycle; return to IDLE.
REQ-024 mem_out_valid outside WAIT_RD SHALL be ignored.
REQ-025 Grant-to-next-grant is at least 3 cycles; write latency from req_ready to mem_in_valid is 1 cycle.
REQ-026 Round-robin: search starts at (last_grant+1) mod NUM_PORTS; last_grant updates only on a grant.
REQ-027 A requester SHALL hold req_valid and its payload until it sees req_ready; dropping req_valid earlier simply withdraws the request.
REQ-028 Simultaneous events: mem_out_valid and a new req_valid in the same WAIT_RD cycle produce no grant that cycle; the grant is evaluated in IDLE.
REQ-029 mem_addr/mem_rw/mem_data_in SHALL hold their last value outside ISSUE.

Reset
REQ-030 On rst low: state=IDLE, last_grant=NUM_PORTS-1, all req_ready/rsp_valid/mem_in_valid=0, mem_* data/address=0, rsp_rdata=0.
REQ-031 Reset mid-operation abandons any pending read; a late mem_out_valid after reset is ignored per REQ-024.
REQ-032 Reset release takes effect on the first clk edge with rst high; no synchronizer inside the block.

Configuration
REQ-033 Macro SDRAM_ARB_FIXED_PRIO_EN: when defined, grant is fixed priority (lowest index wins) and last_grant is unused. When undefined, round-robin per REQ-026. All other behaviour is identical in both cases.

Structure
REQ-034 Package sdram_arb_pkg SHALL hold the state enum and the default ADDR_W/DATA_W constants.
REQ-035 Sub-module sdram_arb_pick SHALL implement the combinational winner select (round-robin or fixed) from the request vector and last_grant.

Verification
REQ-036 Single write: port 2 writes addr 0x00_1234, data 0xDEADBEEF -> req_ready[2] at T, mem_in_valid with matching fields at T+1, back in IDLE at T+3.
REQ-037 Read: port 1 reads 0x7F_FF00; the model returns 0xCAFEF00D 12 cycles after in_valid -> rsp_valid[1]=1 with rsp_rdata=0xCAFEF00D exactly 1 cycle after mem_out_valid, and no other rsp bit set.
REQ-038 Fairness: all 4 ports request continuously (writes) -> grant order 0,1,2,3,0; with SDRAM_ARB_FIXED_PRIO_EN the order is 0,0,0,...
REQ-039 Backpressure: mem_busy held high for 20 cycles with port 0 pending -> no req_ready and no mem_in_valid until mem_busy falls, then grant within 1 cycle.
REQ-040 Reset mid-read: rst low while in WAIT_RD, then mem_out_valid after release -> no rsp_valid, state IDLE, next request granted normally.
REQ-041 Stray strobe: mem_out_valid pulsed in IDLE -> no rsp_valid.
